// File: rtl/slv_guard_rst_ctrl.sv
// slv_guard_rst_ctrl: isolate/assert/settle reset sequencer with 4-phase done handshake to the guard.
// Optional saturating sequence counter enabled by macro SLV_GUARD_RST_CTRL_CNT_EN.
module slv_guard_rst_ctrl #(
  parameter int CntWidth    = 10,
  parameter int IsoTimeout  = 256,
  parameter int RstCntWidth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rst_req_i,
  output logic                   rst_stat_o,
  output logic                   slv_rst_no,
  output logic                   slv_isolate_o,
  input  logic                   isolated_i,
  input  logic [CntWidth-1:0]    assert_cycles_i,
  input  logic [CntWidth-1:0]    settle_cycles_i,
  output logic                   busy_o,
  output logic                   iso_timeout_o,
  output logic [RstCntWidth-1:0] reset_count_o
);
  typedef enum logic [2:0] {IDLE, ISOLATE, ASSERT, SETTLE, DONE} state_e;
  localparam logic [CntWidth-1:0] IsoLast = CntWidth'(IsoTimeout - 1);
  localparam logic [CntWidth-1:0] One     = CntWidth'(1);
  state_e state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d, a_q, a_d, s_q, s_d;
  logic tmo_q, tmo_d, stat_q, stat_d, rst_n_q, rst_n_d, iso_q, iso_d, busy_q, busy_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    a_d     = a_q;
    s_d     = s_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: if (rst_req_i) begin
        state_d = ISOLATE;
        a_d     = (assert_cycles_i == '0) ? One : assert_cycles_i;
        s_d     = settle_cycles_i;
      end
      ISOLATE: begin
        cnt_d = cnt_q + One;
        if (isolated_i || cnt_q == IsoLast) begin
          state_d = ASSERT;
          cnt_d   = '0;
          tmo_d   = tmo_q | ~isolated_i;
        end
      end
      ASSERT: begin
        cnt_d = cnt_q + One;
        if (cnt_q == a_q - One) begin
          state_d = (s_q == '0) ? DONE : SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + One;
        if (cnt_q == s_q - One) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: state_d = rst_req_i ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Output flops track the next state so every output is a plain register.
  always_comb begin
    stat_d  = state_d == DONE;
    rst_n_d = state_d != ASSERT;
    iso_d   = state_d == ISOLATE || state_d == ASSERT || state_d == SETTLE;
    busy_d  = state_d != IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      s_q     <= '0;
      tmo_q   <= 1'b0;
      stat_q  <= 1'b0;
      rst_n_q <= 1'b1;
      iso_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      s_q     <= s_d;
      tmo_q   <= tmo_d;
      stat_q  <= stat_d;
      rst_n_q <= rst_n_d;
      iso_q   <= iso_d;
      busy_q  <= busy_d;
    end
  end
  assign rst_stat_o    = stat_q;
  assign slv_rst_no    = rst_n_q;
  assign slv_isolate_o = iso_q;
  assign busy_o        = busy_q;
  assign iso_timeout_o = tmo_q;
`ifdef SLV_GUARD_RST_CTRL_CNT_EN
  logic [RstCntWidth-1:0] rcnt_q, rcnt_d;
  always_comb rcnt_d = (state_q == DONE && !rst_req_i && rcnt_q != '1) ? rcnt_q + RstCntWidth'(1) : rcnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) rcnt_q <= '0;
    else       rcnt_q <= rcnt_d;
  end
  assign reset_count_o = rcnt_q;
`else
  assign reset_count_o = '0;
`endif
endmodule

// File: tb/tb_slv_guard_rst_ctrl.sv
// tb_slv_guard_rst_ctrl: randomized sequences against a phase-timeline model of the reset sequencer.
module tb_slv_guard_rst_ctrl;
  localparam int T  = 16;
  localparam int RW = 2;
`ifdef SLV_GUARD_RST_CTRL_CNT_EN
  localparam int CMAX = 3;
`else
  localparam int CMAX = 0;
`endif
  logic clk = 1'b0;
  logic rst_i, rst_req_i, isolated_i;
  logic [9:0] assert_cycles_i, settle_cycles_i;
  logic rst_stat_o, slv_rst_no, slv_isolate_o, busy_o, iso_timeout_o;
  logic [RW-1:0] reset_count_o;
  int checks = 0, failures = 0;
  bit tmo_m;
  int cnt_m;
  always #5 clk = ~clk;
  slv_guard_rst_ctrl #(.CntWidth(10), .IsoTimeout(T), .RstCntWidth(RW)) dut (
    .clk_i(clk), .rst_i(rst_i), .rst_req_i(rst_req_i), .rst_stat_o(rst_stat_o),
    .slv_rst_no(slv_rst_no), .slv_isolate_o(slv_isolate_o), .isolated_i(isolated_i),
    .assert_cycles_i(assert_cycles_i), .settle_cycles_i(settle_cycles_i), .busy_o(busy_o),
    .iso_timeout_o(iso_timeout_o), .reset_count_o(reset_count_o)
  );
  // One full sequence: a/s config, isolation ack after d cycles, request low from cycle r on.
  task automatic run_seq(input int a, input int s, input int d, input int r);
    int ae, iso_len, total, done_end;
    bit to;
    logic [3:0] exp, got;
    ae       = (a == 0) ? 1 : a;
    iso_len  = (d < T) ? d + 1 : T;
    to       = d >= T;
    total    = iso_len + ae + s;
    done_end = (r > total) ? r : total;
    @(negedge clk);
    rst_req_i = 1'b1; isolated_i = 1'b0;
    assert_cycles_i = 10'(a); settle_cycles_i = 10'(s);
    for (int t = 0; t <= done_end + 1; t++) begin
      @(posedge clk); #1;
      if (to && t >= iso_len) tmo_m = 1'b1;
      if (t == done_end + 1 && cnt_m < CMAX) cnt_m++;
      exp = (t < iso_len) ? 4'b1110 : (t < iso_len + ae) ? 4'b1100 : (t < total) ? 4'b1110 :
            (t <= done_end) ? 4'b1011 : 4'b0010;
      got = {busy_o, slv_isolate_o, slv_rst_no, rst_stat_o};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL seq_outputs t=%0d a=%0d s=%0d d=%0d r=%0d got{busy,iso,rst_n,stat}=%b exp=%b", t, a, s, d, r, got, exp);
      end
      checks++;
      if (iso_timeout_o !== tmo_m) begin
        failures++;
        $display("FAIL iso_timeout t=%0d d=%0d got=%b exp=%b", t, d, iso_timeout_o, tmo_m);
      end
      checks++;
      if (reset_count_o !== RW'(cnt_m)) begin
        failures++;
        $display("FAIL reset_count t=%0d got=%0d exp=%0d", t, reset_count_o, cnt_m);
      end
      isolated_i = t >= d;
      rst_req_i  = t < r;
      assert_cycles_i = 10'($urandom);
      settle_cycles_i = 10'($urandom);
    end
    isolated_i = 1'b0;
  endtask
  task automatic test_reset();
    @(negedge clk);
    rst_i = 1'b1; rst_req_i = 1'b1; isolated_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tmo_m = 1'b0; cnt_m = 0;
    checks++;
    if ({busy_o, slv_isolate_o, slv_rst_no, rst_stat_o, iso_timeout_o, reset_count_o} !== 7'b0010_0_00) begin
      failures++;
      $display("FAIL reset_values got=%b exp=0010000", {busy_o, slv_isolate_o, slv_rst_no, rst_stat_o, iso_timeout_o, reset_count_o});
    end
    @(negedge clk);
    rst_i = 1'b0; rst_req_i = 1'b0; isolated_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset busy got=%b exp=0", busy_o);
    end
  endtask
  task automatic test_basic();
    run_seq(4, 2, 0, 1);
  endtask
  task automatic test_iso_timeout();
    run_seq(3, 1, T - 1, 0);
    run_seq(2, 0, T, 0);
    run_seq(5, 1, 0, 0);
  endtask
  task automatic test_zero_cfg();
    run_seq(0, 0, 0, 0);
  endtask
  task automatic test_abort();
    @(negedge clk);
    rst_req_i = 1'b1; isolated_i = 1'b1; assert_cycles_i = 10'd8; settle_cycles_i = 10'd3;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (slv_rst_no !== 1'b0) begin
      failures++;
      $display("FAIL abort_in_assert slv_rst_no got=%b exp=0", slv_rst_no);
    end
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk); #1;
    tmo_m = 1'b0; cnt_m = 0;
    checks++;
    if ({busy_o, slv_isolate_o, slv_rst_no, rst_stat_o, iso_timeout_o, reset_count_o} !== 7'b0010_0_00) begin
      failures++;
      $display("FAIL abort_values got=%b exp=0010000", {busy_o, slv_isolate_o, slv_rst_no, rst_stat_o, iso_timeout_o, reset_count_o});
    end
    @(negedge clk);
    rst_i = 1'b0; rst_req_i = 1'b0; isolated_i = 1'b0;
  endtask
  task automatic test_handshake();
    run_seq(3, 2, 0, 1 + 3 + 2 + 20);
    run_seq(2, 1, 0, 0);
  endtask
  task automatic test_random();
    for (int i = 0; i < 12; i++)
      run_seq(int'($urandom_range(0, 20)), int'($urandom_range(0, 10)),
              int'($urandom_range(0, 20)), int'($urandom_range(0, 40)));
  endtask
  task automatic test_counter();
    test_reset();
    for (int i = 0; i < 5; i++) run_seq(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 0, 0);
    checks++;
    if (reset_count_o !== RW'(CMAX)) begin
      failures++;
      $display("FAIL counter_saturate got=%0d exp=%0d", reset_count_o, CMAX);
    end
  endtask
  initial begin
    rst_i = 1'b1; rst_req_i = 1'b0; isolated_i = 1'b0;
    assert_cycles_i = '0; settle_cycles_i = '0;
    test_reset();
    test_basic();
    test_iso_timeout();
    test_zero_cfg();
    test_abort();
    test_handshake();
    test_random();
    test_counter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
